// File: rtl/i2c_slave_core_pkg.sv
// Shared types for the I2C target front end: FSM state encoding and the
// filtered-bus event bundle passed from the input filter to the core.
`timescale 1ns/1ps
package rtcl_p3s7_i2c_pkg;

  localparam int ADDR_BITS = 7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR_ACK,
    WR_DATA,
    RD_ACK,
    RD_DATA,
    RD_MACK,
    IGNORE
  } i2c_state_t;

  // One-cycle bus events plus the filtered SDA level used for sampling.
  typedef struct packed {
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
  } bus_evt_t;

endpackage

// File: rtl/i2c_slave_core_if.sv
// Pad and downstream byte-stream signals of the I2C target, bundled so the
// core and its environment connect through one port.
`timescale 1ns/1ps
interface i2c_slave_core_if;
  logic       i2c_scl_i;
  logic       i2c_sda_i;
  logic       i2c_sda_t;
  logic       i2c_wr_start;
  logic       i2c_wr_en;
  logic [7:0] i2c_wr_data;
  logic       i2c_rd_start;
  logic       i2c_rd_req;
  logic       i2c_rd_en;
  logic [7:0] i2c_rd_data;

  modport slave (
    input  i2c_scl_i, i2c_sda_i, i2c_rd_en, i2c_rd_data,
    output i2c_sda_t, i2c_wr_start, i2c_wr_en, i2c_wr_data, i2c_rd_start, i2c_rd_req
  );

  modport master (
    output i2c_scl_i, i2c_sda_i, i2c_rd_en, i2c_rd_data,
    input  i2c_sda_t, i2c_wr_start, i2c_wr_en, i2c_wr_data, i2c_rd_start, i2c_rd_req
  );
endinterface

// File: rtl/i2c_slave_core_filter.sv
// SCL/SDA input conditioning: 2-FF synchronizer, FILTER_LEN-sample glitch filter,
// and edge/START/STOP event generation from the filtered levels.
`timescale 1ns/1ps
module i2c_slave_filter
  import rtcl_p3s7_i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     scl_i,
  input  logic     sda_i,
  output bus_evt_t evt_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  // Lane 1 = SCL, lane 0 = SDA.
  logic [1:0]            meta_q, sync_q, filt_q, filt_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            rise, fall;

  // A lane flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    // NOTE: every variable gets a default first so no branch can infer a latch.
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      filt_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      meta_q <= {scl_i, sda_i};
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Events are taken from the filter's next value so they coincide with the flip.
  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

  assign evt_o.sda      = filt_q[0];
  assign evt_o.scl_rise = rise[1];
  assign evt_o.scl_fall = fall[1];
  assign evt_o.start    = fall[0] & filt_q[1] & filt_d[1];
  assign evt_o.stop     = rise[0] & filt_q[1] & filt_d[1];

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target core: address match, write/read byte FSM and open-drain SDA control,
// presenting received bytes and read requests as single-cycle pulses.
`timescale 1ns/1ps
module i2c_slave_core
  import rtcl_p3s7_i2c_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] DEV_ADDR   = 7'h10,
  parameter int                   FILTER_LEN = 3
) (
  input logic              clk,
  input logic              reset_n,
  i2c_slave_core_if.slave  bus
);

  bus_evt_t evt;

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .scl_i   (bus.i2c_scl_i),
    .sda_i   (bus.i2c_sda_i),
    .evt_o   (evt)
  );

  i2c_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       sda_t_q, sda_t_d;
  logic       wr_start_q, wr_start_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_start_q, rd_start_d;
  logic       rd_req_q, rd_req_d;

  logic       byte_done;
  logic [2:0] tx_idx;

  assign byte_done = (bit_cnt_q == 4'd8);
  assign tx_idx    = 3'd7 - bit_cnt_q[2:0];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_data_d  = wr_data_q;
    sda_t_d    = sda_t_q;
    wr_start_d = 1'b0;
    wr_en_d    = 1'b0;
    rd_start_d = 1'b0;
    rd_req_d   = 1'b0;

    // The downstream answers in the rd_req cycle; silence means an all-ones byte.
    tx_d = tx_q;
    if (rd_req_q) tx_d = bus.i2c_rd_en ? bus.i2c_rd_data : 8'hFF;

    if (evt.start) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
    end else if (evt.stop) begin
      state_d = IDLE;
      sda_t_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (evt.scl_rise) begin
            shift_d   = {shift_q[6:0], evt.sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (evt.scl_fall && byte_done) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              sda_t_d = 1'b0;
              if (shift_q[0]) begin
                rd_start_d = 1'b1;
                rd_req_d   = 1'b1;
                state_d    = RD_ACK;
              end else begin
                wr_start_d = 1'b1;
                state_d    = WR_ACK;
              end
            end else begin
              state_d = IGNORE;
            end
          end
        end
        WR_ACK: begin
          if (evt.scl_fall) begin
            sda_t_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end
        WR_DATA: begin
          if (evt.scl_rise) begin
            shift_d   = {shift_q[6:0], evt.sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (evt.scl_fall && byte_done) begin
            sda_t_d   = 1'b0;
            wr_data_d = shift_q;
            wr_en_d   = 1'b1;
            state_d   = WR_ACK;
          end
        end
        RD_ACK: begin
          if (evt.scl_fall) begin
            sda_t_d   = tx_q[7];
            bit_cnt_d = 4'd1;
            state_d   = RD_DATA;
          end
        end
        RD_DATA: begin
          if (evt.scl_fall) begin
            if (byte_done) begin
              sda_t_d = 1'b1;
              state_d = RD_MACK;
            end else begin
              sda_t_d   = tx_q[tx_idx];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_MACK: begin
          if (evt.scl_rise) begin
            if (!evt.sda) begin
              rd_req_d = 1'b1;
              state_d  = RD_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE:  sda_t_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      wr_data_q  <= '0;
      sda_t_q    <= 1'b1;
      wr_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_start_q <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_data_q  <= wr_data_d;
      sda_t_q    <= sda_t_d;
      wr_start_q <= wr_start_d;
      wr_en_q    <= wr_en_d;
      rd_start_q <= rd_start_d;
      rd_req_q   <= rd_req_d;
    end
  end

  assign bus.i2c_sda_t    = sda_t_q;
  assign bus.i2c_wr_start = wr_start_q;
  assign bus.i2c_wr_en    = wr_en_q;
  assign bus.i2c_wr_data  = wr_data_q;
  assign bus.i2c_rd_start = rd_start_q;
  assign bus.i2c_rd_req   = rd_req_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-level I2C master drives the pads, a downstream
// responder serves read bytes, and transactions are compared with a transfer-level model.
`timescale 1ns/1ps
module tb_i2c_slave_core;

  localparam logic [6:0] DEV = 7'h10;
  localparam int         Q   = 10;   // clk cycles per quarter SCL period

  typedef struct packed {
    logic            rw;
    logic [6:0]      addr;
    logic [2:0]      n;
    logic [3:0][7:0] d;       // d[0] is the first byte on the bus
    logic            resp;    // downstream answers rd_req with rd_en
    logic            glitch;
    logic            exp_ack;
    logic [3:0][7:0] exp_d;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_core_if bus();

  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       resp_en = 1'b1;
  logic       glitch_en = 1'b0;
  logic [7:0] rd_bytes [256];
  logic [7:0] rd_idx = 8'd0;
  logic       pop_pending = 1'b0;

  assign bus.i2c_scl_i   = m_scl;
  assign bus.i2c_sda_i   = m_sda & bus.i2c_sda_t;
  assign bus.i2c_rd_en   = bus.i2c_rd_req & resp_en;
  assign bus.i2c_rd_data = rd_bytes[rd_idx];

  i2c_slave_core #(.DEV_ADDR(DEV), .FILTER_LEN(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_start_cnt = 0;
  int rd_start_cnt = 0;
  int rd_req_cnt = 0;
  logic [7:0] wr_log [$];

  // Downstream side: count pulses, log written bytes, advance the read source after each request.
  always @(negedge clk) begin
    if (pop_pending) rd_idx <= rd_idx + 8'd1;
    pop_pending <= bus.i2c_rd_req;
    if (bus.i2c_wr_start) wr_start_cnt <= wr_start_cnt + 1;
    if (bus.i2c_rd_start) rd_start_cnt <= rd_start_cnt + 1;
    if (bus.i2c_rd_req)   rd_req_cnt   <= rd_req_cnt + 1;
    if (bus.i2c_wr_en)    wr_log.push_back(bus.i2c_wr_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_bit(input logic b);
    int g;
    g = $urandom_range(1, 2);
    m_sda = b;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    if (glitch_en) begin
      m_sda = ~b;
      tick(g);
      m_sda = b;
    end
    tick(Q);
    m_scl = 1'b0;
    if (glitch_en) begin
      tick(Q / 2);
      m_scl = 1'b1;
      tick(g);
      m_scl = 1'b0;
      tick(Q - Q / 2 - g);
    end else begin
      tick(Q);
    end
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    b = bus.i2c_sda_i;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(b);
    ack = ~b;
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(~ack);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(2 * Q);
  endtask

  // Transfer-level expectation: only our address is acknowledged, and a silent
  // downstream makes every read byte 0xFF.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_ack = (v.addr == DEV);
    for (int i = 0; i < 4; i++) r.exp_d[i] = (v.rw && !v.resp) ? 8'hFF : v.d[i];
    return r;
  endfunction

  function automatic vec_t mk(input logic rw, input logic [6:0] addr, input logic [2:0] n,
                              input logic [31:0] d, input logic resp, input logic glitch,
                              input logic exp_ack, input logic [31:0] exp_d);
    vec_t v;
    v.rw = rw; v.addr = addr; v.n = n; v.d = d; v.resp = resp; v.glitch = glitch;
    v.exp_ack = exp_ack; v.exp_d = exp_d;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int k);
    int ws, rs, rq, base, n;
    logic ack;
    logic [7:0] b;
    ws = wr_start_cnt; rs = rd_start_cnt; rq = rd_req_cnt; base = wr_log.size();
    n = int'(v.n);
    resp_en = v.resp;
    for (int i = 0; i < 4; i++) rd_bytes[8'(int'(rd_idx) + i)] = v.d[i];
    glitch_en = v.glitch;
    i2c_start();
    wr_byte({v.addr, v.rw}, ack);
    check($sformatf("v%0d addr_ack", k), 32'(ack), 32'(v.exp_ack));
    if (!v.rw) begin
      for (int i = 0; i < n; i++) begin
        wr_byte(v.d[i], ack);
        check($sformatf("v%0d data_ack%0d", k, i), 32'(ack), 32'(v.exp_ack));
      end
    end else if (ack) begin
      for (int i = 0; i < n; i++) begin
        rd_byte(b, i < n - 1);
        check($sformatf("v%0d rd_byte%0d", k, i), 32'(b), 32'(v.exp_d[i]));
      end
    end
    glitch_en = 1'b0;
    i2c_stop();
    tick(4);
    check($sformatf("v%0d sda_released", k), 32'(bus.i2c_sda_t), 32'd1);
    if (!v.rw) begin
      check($sformatf("v%0d wr_start_cnt", k), 32'(wr_start_cnt - ws), 32'(v.exp_ack));
      check($sformatf("v%0d wr_en_cnt", k), 32'(wr_log.size() - base), v.exp_ack ? 32'(n) : 32'd0);
      for (int i = 0; i < n; i++)
        if (v.exp_ack && base + i < wr_log.size())
          check($sformatf("v%0d wr_data%0d", k, i), 32'(wr_log[base + i]), 32'(v.exp_d[i]));
    end else begin
      check($sformatf("v%0d rd_start_cnt", k), 32'(rd_start_cnt - rs), 32'(v.exp_ack));
      check($sformatf("v%0d rd_req_cnt", k), 32'(rd_req_cnt - rq), v.exp_ack ? 32'(n) : 32'd0);
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [7];
    vec_t v;
    int ws, rs, rq, base;
    logic ack;
    logic [7:0] b;

    tbl[0] = mk(1'b0, 7'h10, 3'd4, {8'h78, 8'h56, 8'h34, 8'h12}, 1'b1, 1'b0, 1'b1, {8'h78, 8'h56, 8'h34, 8'h12});
    tbl[1] = mk(1'b1, 7'h10, 3'd3, {8'h00, 8'h0F, 8'h3C, 8'hA5}, 1'b1, 1'b0, 1'b1, {8'h00, 8'h0F, 8'h3C, 8'hA5});
    tbl[2] = mk(1'b0, 7'h21, 3'd2, {8'h00, 8'h00, 8'h55, 8'h66}, 1'b1, 1'b0, 1'b0, {8'h00, 8'h00, 8'h55, 8'h66});
    tbl[3] = mk(1'b1, 7'h10, 3'd2, {8'h00, 8'h00, 8'h11, 8'h22}, 1'b0, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
    tbl[4] = mk(1'b0, 7'h10, 3'd3, {8'h00, 8'h01, 8'h5A, 8'hC3}, 1'b1, 1'b1, 1'b1, {8'h00, 8'h01, 8'h5A, 8'hC3});
    tbl[5] = mk(1'b1, 7'h11, 3'd1, {8'h00, 8'h00, 8'h00, 8'h99}, 1'b1, 1'b0, 1'b0, {8'h00, 8'h00, 8'h00, 8'h99});
    tbl[6] = mk(1'b0, 7'h10, 3'd2, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b1, 1'b0, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFF});

    for (int i = 0; i < 256; i++) rd_bytes[i] = 8'h00;

    // Reset state
    tick(5);
    check("rst sda_t", 32'(bus.i2c_sda_t), 32'd1);
    check("rst pulses", 32'({bus.i2c_wr_start, bus.i2c_wr_en, bus.i2c_rd_start, bus.i2c_rd_req}), 32'd0);
    check("rst wr_data", 32'(bus.i2c_wr_data), 32'd0);
    reset_n = 1'b1;
    tick(Q);

    for (int k = 0; k < 7; k++) run_vec(tbl[k], k);

    // Write one byte, then repeated START into a read
    ws = wr_start_cnt; rs = rd_start_cnt; rq = rd_req_cnt; base = wr_log.size();
    resp_en = 1'b1;
    i2c_start();
    wr_byte(8'h20, ack);
    check("rs addr_w_ack", 32'(ack), 32'd1);
    wr_byte(8'hAB, ack);
    check("rs data_ack", 32'(ack), 32'd1);
    rd_bytes[rd_idx] = 8'h96;
    i2c_start();
    wr_byte(8'h21, ack);
    check("rs addr_r_ack", 32'(ack), 32'd1);
    rd_byte(b, 1'b0);
    check("rs rd_byte", 32'(b), 32'h96);
    i2c_stop();
    tick(4);
    check("rs wr_en_cnt", 32'(wr_log.size() - base), 32'd1);
    if (wr_log.size() > base) check("rs wr_data", 32'(wr_log[base]), 32'hAB);
    check("rs wr_start_cnt", 32'(wr_start_cnt - ws), 32'd1);
    check("rs rd_start_cnt", 32'(rd_start_cnt - rs), 32'd1);
    check("rs rd_req_cnt", 32'(rd_req_cnt - rq), 32'd1);

    // Reset asserted while the target drives a 0 read bit
    rd_bytes[rd_idx] = 8'h00;
    i2c_start();
    wr_byte(8'h21, ack);
    check("mr addr_ack", 32'(ack), 32'd1);
    check("mr drive_low", 32'(bus.i2c_sda_t), 32'd0);
    #3 reset_n = 1'b0;
    #1;
    check("mr sda_release", 32'(bus.i2c_sda_t), 32'd1);
    check("mr pulses", 32'({bus.i2c_wr_start, bus.i2c_wr_en, bus.i2c_rd_start, bus.i2c_rd_req}), 32'd0);
    check("mr wr_data", 32'(bus.i2c_wr_data), 32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(Q);
    i2c_stop();
    run_vec(model(mk(1'b0, DEV, 3'd1, 32'h0000_005A, 1'b1, 1'b0, 1'b0, 32'd0)), 100);

    // Randomized transfers against the model
    for (int k = 0; k < 10; k++) begin
      v.rw     = 1'($urandom_range(0, 1));
      v.addr   = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      v.n      = 3'($urandom_range(1, 4));
      v.d      = 32'($urandom());
      v.resp   = ($urandom_range(0, 4) != 0);
      v.glitch = 1'($urandom_range(0, 1));
      v.exp_ack = 1'b0;
      v.exp_d   = '0;
      run_vec(model(v), 200 + k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
